nonce_result_scanner: RTL



---
 rtl/nonce_result_scanner.sv | 106 ++++++++++
 1 files changed

// File: rtl/nonce_result_scanner.sv
// Scans NUM_NONCES consecutive H0 result words from shared memory and reports
// the first word below the difficulty target plus the overall minimum word.
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        found,
    output logic [7:0]  first_nonce,
    output logic [31:0] min_value,
    output logic [7:0]  min_nonce
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [8:0] LAST_IDX = 9'(NUM_NONCES - 1);

    state_t     state;
    logic [8:0] issue_idx;
    logic [8:0] cap_idx;
    logic       issue_live;
    logic       cap_live;

    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_write_data = '0;

    // issue_live/cap_live form a two-stage valid pipe matching the memory's
    // two-edge read latency, so captures start exactly two edges after issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            found       <= 1'b0;
            first_nonce <= '0;
            min_value   <= '1;
            min_nonce   <= '0;
            mem_addr    <= '0;
            issue_idx   <= '0;
            cap_idx     <= '0;
            issue_live  <= 1'b0;
            cap_live    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr    <= result_addr;
                        issue_idx   <= 9'd1;
                        cap_idx     <= '0;
                        found       <= 1'b0;
                        first_nonce <= '0;
                        min_value   <= '1;
                        min_nonce   <= '0;
                        done        <= 1'b0;
                        issue_live  <= 1'b1;
                        cap_live    <= 1'b0;
                        state       <= (NUM_NONCES == 1) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    mem_addr  <= mem_addr + 16'd1;
                    issue_idx <= issue_idx + 9'd1;
                    cap_live  <= issue_live;
                    if (issue_idx == LAST_IDX) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    cap_live   <= issue_live;
                    issue_live <= 1'b0;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Strict less-than on the minimum keeps the earliest index on ties.
            if ((state == ISSUE || state == DRAIN) && cap_live) begin
                if (mem_read_data < target && !found) begin
                    found       <= 1'b1;
                    first_nonce <= cap_idx[7:0];
                end
                if (mem_read_data < min_value) begin
                    min_value <= mem_read_data;
                    min_nonce <= cap_idx[7:0];
                end
                cap_idx <= cap_idx + 9'd1;
                if (cap_idx == LAST_IDX) begin
                    state <= DONE;
                end
            end
        end
    end

endmodule
